// File: rtl/fdt_tx_scheduler.sv
// fdt_tx_scheduler
//   Frame delay timer and send scheduler for the ISO/IEC 14443-3A PICC
//   transmit path. Times the gap from the end of the last PCD pause and
//   fires fdt_trigger on the bit grid (n*128+84 or n*128+20 carrier cycles).
//   It retries on later grid slots while no reply is pending, gives up after
//   MAX_N, and follows the PICC transmission until it ends.
//
// Ports
//   clk                  13.56 MHz carrier clock
//   rst_n                asynchronous active-low reset
//   pause_n_synchronised PCD pause detector (0 during a pause), clk domain
//   rx_eof               1-cycle pulse: PCD frame complete
//   rx_last_bit          last received bit, valid with rx_eof
//   rx_error             1-cycle pulse: receive framing error
//   tx_pending           reply data valid at the frame encoder
//   tx_active            frame encoder data_valid (PICC transmitting)
//   fdt_trigger          1-cycle pulse: start the reply now
//   fdt_expired          1-cycle pulse: reply window closed, nothing sent
//   armed                high while waiting for a grid slot
module fdt_tx_scheduler #(
    parameter int MIN_N          = 9,
    parameter int MAX_N          = 31,
    parameter int TRIGGER_OFFSET = 0,
    parameter int CNT_W          = $clog2((MAX_N + 1) * 128 + 84 + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pause_n_synchronised,
    input  logic rx_eof,
    input  logic rx_last_bit,
    input  logic rx_error,
    input  logic tx_pending,
    input  logic tx_active,
    output logic fdt_trigger,
    output logic fdt_expired,
    output logic armed
);

    // n runs up to MAX_N+1, the slot that signals expiry.
    localparam int N_W = $clog2(MAX_N + 2);

    typedef enum logic [1:0] {IDLE, MEASURE, ARMED, TX} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] target;
    logic [N_W-1:0]   n;
    logic             base_hi;     // 1: grid offset 84, 0: grid offset 20
    logic             pause_prev;
    logic             tx_seen;
    logic [1:0]       tx_wait;     // cycles in TX without tx_active
    logic             pause_edge;
    logic             hit;
    logic             in_window;
    logic             slot_ok;

    assign pause_edge = !pause_prev && pause_n_synchronised;
    assign target     = (CNT_W'(n) << 7)
                      + (base_hi ? CNT_W'(84) : CNT_W'(20))
                      - CNT_W'(TRIGGER_OFFSET);
    assign hit        = (count == target);
    assign in_window  = (int'(n) <= MAX_N);

    // A new pause or a framing error in the slot cycle cancels the slot.
    assign slot_ok    = (state == ARMED) && hit && !pause_edge && !rx_error;

    // Decoded from registered state so the pulse lands on the exact grid
    // cycle and a same-cycle pause edge can still suppress it.
    assign fdt_trigger = slot_ok && in_window;
    assign fdt_expired = slot_ok && !in_window;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            n          <= N_W'(MIN_N);
            base_hi    <= 1'b0;
            pause_prev <= 1'b1;
            tx_seen    <= 1'b0;
            tx_wait    <= '0;
            armed      <= 1'b0;
        end else begin
            pause_prev <= pause_n_synchronised;

            // Free-running, saturating; a clear below overrides this.
            if ((state == MEASURE || state == ARMED) && count != '1)
                count <= count + 1'b1;

            case (state)
                IDLE: begin
                    if (pause_edge) begin
                        count <= '0;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    // Each pause end restarts timing: the last one counts.
                    if (pause_edge) begin
                        count <= '0;
                    end else if (rx_error) begin
                        state <= IDLE;
                    end else if (rx_eof) begin
                        base_hi <= rx_last_bit;
                        n       <= N_W'(MIN_N);
                        state   <= ARMED;
                        armed   <= 1'b1;
                    end
                end
                ARMED: begin
                    if (pause_edge) begin
                        count <= '0;
                        state <= MEASURE;
                        armed <= 1'b0;
                    end else if (rx_error) begin
                        state <= IDLE;
                        armed <= 1'b0;
                    end else if (hit) begin
                        if (!in_window) begin
                            state <= IDLE;
                            armed <= 1'b0;
                        end else if (tx_pending) begin
                            state   <= TX;
                            armed   <= 1'b0;
                            tx_seen <= 1'b0;
                            tx_wait <= '0;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end
                end
                TX: begin
                    if (tx_active)
                        tx_seen <= 1'b1;
                    if (tx_seen && !tx_active) begin
                        state <= IDLE;
                    end else if (!tx_seen && !tx_active) begin
                        // Encoder never started: don't hang waiting for it.
                        if (tx_wait == 2'd3)
                            state <= IDLE;
                        else
                            tx_wait <= tx_wait + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    armed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdt_tx_scheduler.sv
// Directed bench for fdt_tx_scheduler. Three instances share the stimulus:
//   u0 default parameters, u1 TRIGGER_OFFSET=3, u2 MAX_N=10.
// Cycle T is the cycle in which count reads 0 after a pause end edge.
module tb_fdt_tx_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    logic pause_n_synchronised, rx_eof, rx_last_bit, rx_error, tx_pending, tx_active;
    logic trig0, trig1, trig2, exp0, exp1, exp2, arm0, arm1, arm2;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int both_hi = 0;
    int tq0[$], tq1[$], tq2[$], eq0[$], eq2[$];
    int t, t2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fdt_tx_scheduler u0 (
        .clk(clk), .rst_n(rst_n), .pause_n_synchronised(pause_n_synchronised),
        .rx_eof(rx_eof), .rx_last_bit(rx_last_bit), .rx_error(rx_error),
        .tx_pending(tx_pending), .tx_active(tx_active),
        .fdt_trigger(trig0), .fdt_expired(exp0), .armed(arm0));

    fdt_tx_scheduler #(.TRIGGER_OFFSET(3)) u1 (
        .clk(clk), .rst_n(rst_n), .pause_n_synchronised(pause_n_synchronised),
        .rx_eof(rx_eof), .rx_last_bit(rx_last_bit), .rx_error(rx_error),
        .tx_pending(tx_pending), .tx_active(tx_active),
        .fdt_trigger(trig1), .fdt_expired(exp1), .armed(arm1));

    fdt_tx_scheduler #(.MAX_N(10)) u2 (
        .clk(clk), .rst_n(rst_n), .pause_n_synchronised(pause_n_synchronised),
        .rx_eof(rx_eof), .rx_last_bit(rx_last_bit), .rx_error(rx_error),
        .tx_pending(tx_pending), .tx_active(tx_active),
        .fdt_trigger(trig2), .fdt_expired(exp2), .armed(arm2));

    // Pulse log, sampled mid-cycle.
    always @(negedge clk) begin
        if (trig0) tq0.push_back(cyc);
        if (trig1) tq1.push_back(cyc);
        if (trig2) tq2.push_back(cyc);
        if (exp0)  eq0.push_back(cyc);
        if (exp2)  eq2.push_back(cyc);
        if ((trig0 && exp0) || (trig1 && exp1) || (trig2 && exp2)) both_hi++;
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic clear_q();
        tq0.delete(); tq1.delete(); tq2.delete(); eq0.delete(); eq2.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        clear_q();
    endtask

    // Three cycles of pause, then release; returns T.
    task automatic pause_frame(output int tt);
        pause_n_synchronised = 1'b0;
        repeat (3) step();
        pause_n_synchronised = 1'b1;
        step();
        tt = cyc;
    endtask

    task automatic pulse_eof(input logic b);
        rx_last_bit = b;
        rx_eof = 1'b1;
        step();
        rx_eof = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        pause_n_synchronised = 1'b1;
        rx_eof = 1'b0; rx_last_bit = 1'b0; rx_error = 1'b0;
        tx_pending = 1'b0; tx_active = 1'b0;
        repeat (3) step();
        check("reset_trig", int'(trig0), 0);
        check("reset_exp",  int'(exp0),  0);
        check("reset_arm",  int'(arm0),  0);
        rst_n = 1'b1;
        step();
        clear_q();

        // Last bit 1, reply ready: one trigger at T+1236, then TX.
        tx_pending = 1'b1;
        pause_frame(t);
        wait_until(t + 899); pulse_eof(1'b1);
        wait_until(t + 1000);
        check("s1_armed", int'(arm0), 1);
        wait_until(t + 1237); tx_active = 1'b1;
        wait_until(t + 1437); tx_active = 1'b0;
        wait_until(t + 1700);
        check("s1_trig_cnt", tq0.size(), 1);
        check("s1_trig_at",  qat(tq0, 0), t + 1236);
        check("s1_no_exp",   eq0.size(), 0);
        check("s1_idle",     int'(arm0), 0);

        // Last bit 0: offset 3 -> T+1169, no offset -> T+1172; u1 encoder idle.
        do_reset();
        tx_pending = 1'b1;
        pause_frame(t);
        wait_until(t + 899); pulse_eof(1'b0);
        wait_until(t + 1300);
        check("s2_off_cnt", tq1.size(), 1);
        check("s2_off_at",  qat(tq1, 0), t + 1169);
        check("s2_b0_at",   qat(tq0, 0), t + 1172);
        check("s2_timeout", int'(arm1), 0);

        // Retries: pending only from T+1400 -> 1236, 1364, 1492.
        do_reset();
        tx_pending = 1'b0;
        pause_frame(t);
        wait_until(t + 899); pulse_eof(1'b1);
        wait_until(t + 1399); tx_pending = 1'b1;
        wait_until(t + 1493); tx_active = 1'b1;
        wait_until(t + 1510); tx_active = 1'b0;
        wait_until(t + 1600);
        check("s3_trig_cnt", tq0.size(), 3);
        check("s3_trig0", qat(tq0, 0), t + 1236);
        check("s3_trig1", qat(tq0, 1), t + 1364);
        check("s3_trig2", qat(tq0, 2), t + 1492);
        check("s3_idle",  int'(arm0), 0);

        // MAX_N=10, never pending: two triggers then expiry.
        do_reset();
        tx_pending = 1'b0;
        pause_frame(t);
        wait_until(t + 899); pulse_eof(1'b1);
        wait_until(t + 1500);
        check("s4_trig_cnt", tq2.size(), 2);
        check("s4_trig0", qat(tq2, 0), t + 1236);
        check("s4_trig1", qat(tq2, 1), t + 1364);
        check("s4_exp_cnt", eq2.size(), 1);
        check("s4_exp_at",  qat(eq2, 0), t + 1492);
        check("s4_idle",    int'(arm2), 0);

        // New pause end at T+1000 while ARMED restarts timing.
        do_reset();
        tx_pending = 1'b1;
        pause_frame(t);
        wait_until(t + 899); pulse_eof(1'b1);
        wait_until(t + 996);
        pause_frame(t2);
        check("s5_new_edge_at", t2 - t, 1000);
        check("s5_measure", int'(arm0), 0);
        wait_until(t2 + 899); pulse_eof(1'b1);
        wait_until(t2 + 1237); tx_active = 1'b1;
        wait_until(t2 + 1260); tx_active = 1'b0;
        wait_until(t2 + 1300);
        check("s5_trig_cnt", tq0.size(), 1);
        check("s5_trig_at",  qat(tq0, 0), t2 + 1236);

        // rx_error in MEASURE: the later rx_eof is ignored.
        do_reset();
        tx_pending = 1'b1;
        pause_frame(t);
        wait_until(t + 99);
        rx_error = 1'b1; step(); rx_error = 1'b0;
        wait_until(t + 899); pulse_eof(1'b1);
        wait_until(t + 1600);
        check("s6_err_trig", tq0.size(), 0);
        check("s6_err_arm",  int'(arm0), 0);

        // Reset while ARMED: immediate abort, no pulses afterwards.
        clear_q();
        pause_frame(t);
        wait_until(t + 899); pulse_eof(1'b1);
        wait_until(t + 1100);
        rst_n = 1'b0;
        #1;
        check("s6_rst_arm",  int'(arm0),  0);
        check("s6_rst_trig", int'(trig0), 0);
        check("s6_rst_exp",  int'(exp0),  0);
        step(); step();
        rst_n = 1'b1;
        wait_until(t + 1600);
        check("s6_rst_none", tq0.size() + tq2.size() + eq0.size() + eq2.size(), 0);

        // Next frame timed correctly.
        pause_frame(t);
        wait_until(t + 899); pulse_eof(1'b1);
        wait_until(t + 1237); tx_active = 1'b1;
        wait_until(t + 1250); tx_active = 1'b0;
        wait_until(t + 1300);
        check("s6_next_cnt", tq0.size(), 1);
        check("s6_next_at",  qat(tq0, 0), t + 1236);

        check("never_both", both_hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
